handshake_arbiter: RTL and testbench
====================================

// Module: handshake_arbiter
//
// PURPOSE
//   Round-robin arbiter sharing one valid/ready output channel among NUM_PORTS
//   requester channels. Each requester presents value/valid, and the winner's
//   value is captured into a one-entry output register that drains to a single
//   downstream consumer. It sits between several value-producing handshake
//   sources and one consumer, and tags each output beat with its source port.
//
// PARAMETERS
//   NUM_PORTS   4  number of requester channels (>= 2)
//   DATA_WIDTH  8  width of each value
//   SRC_WIDTH   $clog2(NUM_PORTS)  width of o_source (derived, do not override)
//
// PORTS
//   clock     input   1                      rising-edge clock
//   reset     input   1                      asynchronous, active-high reset
//   i_valid   input   NUM_PORTS              per-requester valid
//   i_value   input   NUM_PORTS*DATA_WIDTH   per-requester value; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready   output  NUM_PORTS              per-requester accept; at most one bit high
//   o_value   output  DATA_WIDTH             output value (registered)
//   o_valid   output  1                      output valid (registered)
//   o_source  output  SRC_WIDTH              index of the port that supplied o_value (registered)
//   i_ready   input   1                      downstream accept
//
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - o_valid=0, o_value=0, o_source=0, last-grant pointer = NUM_PORTS-1, so port 0 has first priority.
//   - o_ready is forced to all zeros while reset is high.
//   Load enable:
//   - load = !o_valid || i_ready. The slot accepts a new beat when it is empty or draining this cycle.
//   Arbitration (combinational):
//   - When load=1, scan ports ptr+1, ptr+2, ... modulo NUM_PORTS. The first k with i_valid[k]=1 wins and o_ready[k]=1.
//   - All other o_ready bits are 0. If load=0 or no i_valid bit is set, o_ready=0.
//   - o_ready may depend combinationally on i_valid and i_ready.
//   Transfer on port k:
//   - Occurs when i_valid[k] && o_ready[k] at a rising edge.
//   - That edge sets o_value<=i_value[k], o_source<=k, o_valid<=1 and ptr<=k.
//   - The pointer changes only on a transfer.
//   Output:
//   - A beat completes on o_valid && i_ready.
//   - If no transfer happens in the same cycle, o_valid<=0. o_value and o_source keep their last values.
//   - While o_valid && !i_ready, o_value, o_source and o_valid hold stable.
//   Latency and throughput:
//   - Input accept to o_valid is 1 cycle.
//   - Back-to-back one beat per cycle is sustained when i_ready stays high (drain and refill in the same cycle).
//   Fairness:
//   - A port holding i_valid high is granted within NUM_PORTS transfers.
//   - A port never wins twice in a row while another port is valid.
//   Requester rules (checked by bench):
//   - i_valid must not drop, and i_value must not change, until the port is accepted.
//   - i_valid/i_value are don't-care for a port that is not valid.
//   Boundaries:
//   - All ports idle: o_ready=0 and the pointer holds.
//   - Single valid port: it wins every load cycle regardless of pointer.
//   - Pointer wrap: after ptr=NUM_PORTS-1 the scan starts at port 0.
//   - Reset mid-operation: any pending beat is dropped, o_valid clears immediately (async), and the pointer returns to NUM_PORTS-1.
//
// TESTING
//   1. Reset: hold reset 10 cycles with all i_valid=1
//      -> o_valid=0, o_value=0, o_source=0, o_ready=0 throughout.
//   2. Single port: only port 2 valid, sending 1..100, with i_ready randomly held low 0..10 cycles
//      -> o_value sequence 1..100 in order, o_source=2 on every beat, no beat lost or duplicated.
//   3. Full contention: all 4 ports valid, i_ready=1
//      -> o_source sequence 0,1,2,3,0,1,... one beat per cycle, first o_valid 1 cycle after release.
//   4. Backpressure: ports 0 and 3 valid, i_ready=0 for 5 cycles after the first beat
//      -> o_value/o_source stable for those 5 cycles, o_ready=0, next beat from port 3.
//   5. Skip and wrap: ptr=1 with only ports 0 and 1 valid -> port 0 granted first, then port 1, then port 0.
//   6. Reset mid-operation: assert reset while o_valid=1 and i_ready=0
//      -> o_valid drops the same cycle, and after release port 0 wins first.

Source files
------------

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS valid/ready requesters into one registered
// output slot. Each output beat is tagged with the index of the port that supplied it.
module handshake_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SRC_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            i_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_value,
  output logic [NUM_PORTS-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]           o_value,
  output logic                            o_valid,
  output logic [SRC_WIDTH-1:0]            o_source,
  input  logic                            i_ready
);

  localparam logic [SRC_WIDTH:0]   NumPortsW = (SRC_WIDTH + 1)'(NUM_PORTS);
  localparam logic [SRC_WIDTH-1:0] LastPort  = SRC_WIDTH'(NUM_PORTS - 1);

  logic [SRC_WIDTH-1:0] ptr_q;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic [SRC_WIDTH:0]   cand;
  logic                 found;
  logic                 load;
  logic                 transfer;

  // The slot can take a new beat when it is empty or is being drained this cycle.
  assign load     = !o_valid || i_ready;
  assign transfer = load && found && !reset;

  // Scan ptr+1, ptr+2, ... modulo NUM_PORTS; the first valid port wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= int'(NUM_PORTS); off++) begin
      cand = {1'b0, ptr_q} + (SRC_WIDTH + 1)'(off);
      if (cand >= NumPortsW) begin
        cand = cand - NumPortsW;
      end
      if (!found && i_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand[SRC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    o_ready = '0;
    if (transfer) begin
      o_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid  <= 1'b0;
      o_value  <= '0;
      o_source <= '0;
      ptr_q    <= LastPort;
    end else if (transfer) begin
      o_valid  <= 1'b1;
      o_value  <= i_value[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      o_source <= grant_idx;
      ptr_q    <= grant_idx;
    end else if (i_ready) begin
      // Value and source are left as they were; only the valid flag drops.
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Randomised bench for handshake_arbiter: rule-following requesters, a transaction-level
// round-robin model, and directed reset / sequencing scenarios.
module tb_handshake_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    i_valid;
  logic [N*W-1:0]  i_value;
  logic [N-1:0]    o_ready;
  logic [W-1:0]    o_value;
  logic            o_valid;
  logic [SW-1:0]   o_source;
  logic            i_ready;

  handshake_arbiter #(
    .NUM_PORTS (N),
    .DATA_WIDTH(W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .i_value (i_value),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_valid (o_valid),
    .o_source(o_source),
    .i_ready (i_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: output slot contents, last winner, and per-port pending beats.
  bit m_valid;
  int m_value;
  int m_src;
  int m_ptr;
  bit pend[N];
  int pval[N];
  int seq[N];
  int rdy_hold;
  int next_expect;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_value  = 0;
    m_src    = 0;
    m_ptr    = N - 1;
    rdy_hold = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      pval[k] = 0;
    end
  endtask

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic run(input int cycles, input logic [N-1:0] mask, input int p_new,
                     input bit rand_rdy, input bit seq_mode);
    for (int c = 0; c < cycles; c++) begin
      int g;
      logic [N-1:0] exp_ready;
      check("o_valid", o_valid, m_valid);
      check("o_value", o_value, m_value[W-1:0]);
      check("o_source", o_source, m_src[SW-1:0]);

      for (int k = 0; k < N; k++) begin
        if (!pend[k] && mask[k] && int'($urandom_range(99)) < p_new) begin
          if (!seq_mode) begin
            pend[k] = 1'b1;
            pval[k] = int'($urandom_range(255));
          end else if (seq[k] < 100) begin
            seq[k]++;
            pend[k] = 1'b1;
            pval[k] = seq[k];
          end
        end
        i_valid[k]          = pend[k];
        i_value[k*W +: W]   = pend[k] ? W'(pval[k]) : W'($urandom);
      end

      if (!rand_rdy) begin
        i_ready = 1'b1;
      end else if (rdy_hold > 0) begin
        i_ready = 1'b0;
        rdy_hold--;
      end else begin
        i_ready = 1'b1;
        if ($urandom_range(3) == 0) rdy_hold = int'($urandom_range(10));
      end
      #1;

      g = -1;
      if (!m_valid || i_ready) begin
        for (int off = 1; off <= N; off++) begin
          int k;
          k = (m_ptr + off) % N;
          if (g < 0 && pend[k]) g = k;
        end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      check("o_ready", o_ready, exp_ready);

      if (seq_mode && m_valid && i_ready) begin
        check("seq_value", o_value, next_expect[W-1:0]);
        next_expect++;
      end

      if (g >= 0) begin
        m_value = pval[g];
        m_src   = g;
        m_valid = 1'b1;
        m_ptr   = g;
        pend[g] = 1'b0;
      end else if (i_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = '1;
    i_value = '1;
    i_ready = 1'b1;
    model_reset();
    for (int k = 0; k < N; k++) seq[k] = 0;

    // Reset held with every requester valid.
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_value", o_value, '0);
      check("rst_o_source", o_source, '0);
      check("rst_o_ready", o_ready, '0);
    end
    i_valid = '0;
    reset   = 1'b0;
    @(posedge clock);
    #1;

    // Port 2 alone sends 1..100 under random backpressure.
    next_expect = 1;
    run(1500, 4'b0100, 70, 1'b1, 1'b1);
    check("seq_count", next_expect, 101);

    // Contention, backpressure, skip and wrap patterns.
    run(200, 4'b1111, 100, 1'b0, 1'b0);
    run(300, 4'b1001, 60, 1'b1, 1'b0);
    run(300, 4'b0011, 80, 1'b1, 1'b0);
    run(400, 4'b1111, 50, 1'b1, 1'b0);
    run(200, 4'b0000, 50, 1'b1, 1'b0);

    // Reset while a beat is stalled in the output slot.
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    i_valid = 4'b0010;
    i_value = '0;
    i_value[1*W +: W] = 8'h5a;
    i_ready = 1'b0;
    @(posedge clock);
    #1;
    check("pre_rst_valid", o_valid, 1'b1);
    check("pre_rst_value", o_value, 8'h5a);
    reset = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_ready", o_ready, '0);
    @(negedge clock);
    i_valid = '0;
    reset   = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    run(100, 4'b1111, 100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
